boxcar_decimator: RTL and testbench

- Downstream stage of the boxcar low-pass filter; consumes its filtered sample stream at the sample-tick rate.
- Keeps one sample out of every 2^k ticks, with k selectable at run time in power-of-two steps to match the filter's coarse band selection.
- Delivers kept samples through a 2-entry valid/ready output buffer, so a stalling consumer loses samples only on true overflow, and flags that overflow.

---
 rtl/boxcar_decimator.sv | 178 +++++++++++++++++
 tb/tb_boxcar_decimator.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/boxcar_decimator.sv
// Boxcar decimator: keeps one filtered sample out of every 2^k sample ticks.
// Latency: a kept sample is on data_o one register stage after its tick edge.
// Backpressure: 2-entry valid/ready output buffer; a push into a full buffer
// without a simultaneous pop drops the new sample and sets sticky overflow_o.
// Optional macro BOXCAR_DECIMATOR_DROP_CNT_EN adds a saturating drop counter.
module boxcar_decimator #(
  parameter int DW             = 16,
  parameter int MAX_DECIM_LOG2 = 5,
  localparam int KW            = $clog2(MAX_DECIM_LOG2 + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          sample_tick_i,
  input  logic [DW-1:0] data_i,
  input  logic [KW-1:0] decim_log2_i,
  input  logic          flush_i,
  input  logic          clr_ovf_i,
  output logic [DW-1:0] data_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic          overflow_o
`ifdef BOXCAR_DECIMATOR_DROP_CNT_EN
  ,
  output logic [15:0]   drop_cnt_o
`endif
);

  localparam int PW = MAX_DECIM_LOG2;

  logic [PW-1:0] phase_q, phase_d;
  logic [KW-1:0] k_act_q, k_act_d;
  logic [DW-1:0] head_q, head_d;
  logic [DW-1:0] tail_q, tail_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  logic [KW-1:0] k_req;
  logic [KW-1:0] k_eff;
  logic [PW:0]   span;
  logic [PW:0]   term;
  logic          phase_zero;
  logic          period_end;
  logic          keep;
  logic          pop;
  logic          drop;

  // Requested ratio clamped to the largest supported one.
  assign k_req = (decim_log2_i > KW'(MAX_DECIM_LOG2)) ? KW'(MAX_DECIM_LOG2) : decim_log2_i;

  // At a period boundary the freshly latched ratio already decides the period length.
  assign phase_zero = (phase_q == '0);
  assign k_eff      = phase_zero ? k_req : k_act_q;
  assign span       = (PW + 1)'(1) << k_eff;
  assign term       = span - (PW + 1)'(1);
  assign period_end = (phase_q == term[PW-1:0]);

  // Next-state logic: phase/ratio tracking, buffer update and overflow detection.
  always_comb begin
    phase_d = phase_q;
    k_act_d = k_act_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    keep    = 1'b0;
    drop    = 1'b0;
    // ready_i only matters while the buffer holds something.
    pop     = (cnt_q != 2'd0) && ready_i;

    if (flush_i) begin
      // Flush beats a coincident tick; head value is left in place on purpose.
      phase_d = '0;
      cnt_d   = 2'd0;
      pop     = 1'b0;
    end else begin
      if (sample_tick_i) begin
        if (phase_zero) begin
          k_act_d = k_req;
        end
        keep    = phase_zero;
        phase_d = period_end ? '0 : phase_q + PW'(1);
      end

      case (cnt_q)
        2'd0: begin
          if (keep) begin
            head_d = data_i;
            cnt_d  = 2'd1;
          end
        end
        2'd1: begin
          if (keep && pop) begin
            head_d = data_i;
          end else if (keep) begin
            tail_d = data_i;
            cnt_d  = 2'd2;
          end else if (pop) begin
            cnt_d = 2'd0;
          end
        end
        default: begin
          if (keep && pop) begin
            head_d = tail_q;
            tail_d = data_i;
          end else if (pop) begin
            head_d = tail_q;
            cnt_d  = 2'd1;
          end else if (keep) begin
            drop = 1'b1;
          end
        end
      endcase
    end

    // A new drop outranks a clear in the same cycle.
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf_i) begin
      ovf_d = 1'b0;
    end
  end

  // Phase counter and active ratio registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase_q <= '0;
      k_act_q <= '0;
    end else begin
      phase_q <= phase_d;
      k_act_q <= k_act_d;
    end
  end

  // Output buffer storage, occupancy and sticky overflow.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
      ovf_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign data_o     = head_q;
  assign valid_o    = (cnt_q != 2'd0);
  assign overflow_o = ovf_q;

`ifdef BOXCAR_DECIMATOR_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [15:0] drop_base;

  // Saturating drop counter; clear applies first so clear+drop yields 1.
  always_comb begin
    drop_base  = clr_ovf_i ? 16'h0000 : drop_cnt_q;
    drop_cnt_d = drop_base;
    if (drop && (drop_base != 16'hFFFF)) begin
      drop_cnt_d = drop_base + 16'h0001;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      drop_cnt_q <= 16'h0000;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_boxcar_decimator.sv
// Directed bench for boxcar_decimator with hand-computed expectations.
module tb_boxcar_decimator;

  localparam int DW   = 16;
  localparam int MAXL = 5;
  localparam int KW   = $clog2(MAXL + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          sample_tick;
  logic [DW-1:0] data_in;
  logic [KW-1:0] decim_log2;
  logic          flush;
  logic          clr_ovf;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          ready;
  logic          overflow;
`ifdef BOXCAR_DECIMATOR_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  boxcar_decimator #(.DW(DW), .MAX_DECIM_LOG2(MAXL)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .sample_tick_i (sample_tick),
    .data_i        (data_in),
    .decim_log2_i  (decim_log2),
    .flush_i       (flush),
    .clr_ovf_i     (clr_ovf),
    .data_o        (data_out),
    .valid_o       (valid_out),
    .ready_i       (ready),
    .overflow_o    (overflow)
`ifdef BOXCAR_DECIMATOR_DROP_CNT_EN
    ,
    .drop_cnt_o    (drop_cnt)
`endif
  );

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_tick(input int v);
    sample_tick = 1'b1;
    data_in     = DW'(v);
    step(1);
    sample_tick = 1'b0;
  endtask

  initial begin
    logic exp_keep;

    rst         = 1'b1;
    sample_tick = 1'b0;
    data_in     = '0;
    decim_log2  = '0;
    flush       = 1'b0;
    clr_ovf     = 1'b0;
    ready       = 1'b0;
    #12;
    chk_val("rst_valid", 32'(valid_out), 32'd0);
    chk_val("rst_data", 32'(data_out), 32'd0);
    chk_val("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    step(1);

    // Ratio 4, ticks every 4 clocks, consumer always ready.
    decim_log2 = KW'(2);
    ready      = 1'b1;
    for (int i = 0; i < 16; i++) begin
      do_tick(i);
      if (i % 4 == 0) begin
        chk_val("k2_valid", 32'(valid_out), 32'd1);
        chk_val("k2_data", 32'(data_out), 32'(i));
        step(1);
        chk_val("k2_pulse", 32'(valid_out), 32'd0);
        step(2);
      end else begin
        chk_val("k2_skip", 32'(valid_out), 32'd0);
        step(3);
      end
    end
    chk_val("k2_ovf", 32'(overflow), 32'd0);

    // Ratio 1 into a stalled consumer: two buffered, two dropped.
    decim_log2 = KW'(0);
    ready      = 1'b0;
    do_tick(10);
    do_tick(11);
    do_tick(12);
    do_tick(13);
    chk_val("ovf_head", 32'(data_out), 32'd10);
    chk_val("ovf_valid", 32'(valid_out), 32'd1);
    chk_val("ovf_flag", 32'(overflow), 32'd1);
`ifdef BOXCAR_DECIMATOR_DROP_CNT_EN
    chk_val("ovf_dropcnt", 32'(drop_cnt), 32'd2);
`endif
    step(2);
    chk_val("stall_hold", 32'(data_out), 32'd10);
    ready = 1'b1;
    step(1);
    chk_val("drain_1", 32'(data_out), 32'd11);
    chk_val("drain_1v", 32'(valid_out), 32'd1);
    step(1);
    chk_val("drain_empty", 32'(valid_out), 32'd0);
    clr_ovf = 1'b1;
    step(1);
    clr_ovf = 1'b0;
    chk_val("clr_ovf", 32'(overflow), 32'd0);
`ifdef BOXCAR_DECIMATOR_DROP_CNT_EN
    chk_val("clr_dropcnt", 32'(drop_cnt), 32'd0);
`endif

    // Full buffer with simultaneous push and pop keeps occupancy at 2.
    ready = 1'b0;
    do_tick(10);
    do_tick(11);
    ready = 1'b1;
    do_tick(12);
    chk_val("pp_head", 32'(data_out), 32'd11);
    chk_val("pp_ovf", 32'(overflow), 32'd0);
    step(1);
    chk_val("pp_next", 32'(data_out), 32'd12);
    chk_val("pp_nextv", 32'(valid_out), 32'd1);
    step(1);
    chk_val("pp_empty", 32'(valid_out), 32'd0);

    // Mid-period ratio change: 8, then 2, then clamped 32.
    for (int i = 0; i < 47; i++) begin
      decim_log2 = (i < 3) ? KW'(3) : (i < 13) ? KW'(1) : KW'(7);
      exp_keep   = (i == 0) || (i == 8) || (i == 10) || (i == 12) || (i == 14) || (i == 46);
      do_tick(100 + i);
      chk_val("ratio_keep", 32'(valid_out), 32'(exp_keep));
      if (exp_keep) begin
        chk_val("ratio_data", 32'(data_out), 32'(100 + i));
      end
      step(1);
    end

    // Flush with a coincident tick; overflow must survive the flush.
    flush = 1'b1;
    step(1);
    flush      = 1'b0;
    decim_log2 = KW'(0);
    ready      = 1'b0;
    do_tick(20);
    do_tick(21);
    do_tick(22);
    chk_val("fl_pre_ovf", 32'(overflow), 32'd1);
    flush = 1'b1;
    do_tick(99);
    flush = 1'b0;
    chk_val("fl_valid", 32'(valid_out), 32'd0);
    chk_val("fl_hold", 32'(data_out), 32'd20);
    chk_val("fl_ovf", 32'(overflow), 32'd1);
    step(1);
    chk_val("fl_no99", 32'(valid_out), 32'd0);
    do_tick(55);
    chk_val("fl_next_v", 32'(valid_out), 32'd1);
    chk_val("fl_next_d", 32'(data_out), 32'd55);
`ifdef BOXCAR_DECIMATOR_DROP_CNT_EN
    chk_val("fl_dropcnt", 32'(drop_cnt), 32'd1);
`endif
    ready = 1'b1;
    step(1);
    chk_val("fl_drain", 32'(valid_out), 32'd0);

    // Asynchronous reset between edges.
    ready = 1'b0;
    do_tick(30);
    do_tick(31);
    #3;
    rst = 1'b1;
    #1;
    chk_val("arst_valid", 32'(valid_out), 32'd0);
    chk_val("arst_data", 32'(data_out), 32'd0);
    chk_val("arst_ovf", 32'(overflow), 32'd0);
    #2;
    rst = 1'b0;
    step(1);
    do_tick(40);
    chk_val("post_rst_v", 32'(valid_out), 32'd1);
    chk_val("post_rst_d", 32'(data_out), 32'd40);
    ready = 1'b1;
    do_tick(41);
    chk_val("post_rst_2", 32'(data_out), 32'd41);
    chk_val("post_rst_ovf", 32'(overflow), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
